// File: rtl/uart_pkg.sv
// Shared UART-path definitions: transmit FSM states, ASCII constants and
// the double-dabble step used by bin2bcd.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_LOAD,
    ST_WAIT,
    ST_DONE
  } tx_state_e;

  localparam logic [7:0] ASCII_0     = 8'd48;
  localparam logic [7:0] ASCII_PLUS  = 8'd43;
  localparam logic [7:0] ASCII_MINUS = 8'd45;
  localparam logic [7:0] ASCII_LF    = 8'd10;

  // Shift register layout: [19:8] = three BCD digits, [7:0] = remaining binary.
  function automatic logic [19:0] dabble_step(input logic [19:0] sh);
    logic [19:0] t;
    t = sh;
    for (int unsigned i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, 8 shifts).
// A start pulse latches the input; done pulses once when bcd is valid.
module bin2bcd
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  logic [19:0] sh_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  // The first shift needs no add-3 (digits are zero), so it is folded into
  // the load; the remaining 7 shifts leave done high in the 8th busy cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        sh_q   <= {11'd0, bin, 1'b0};
        cnt_q  <= 3'd7;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        sh_q  <= dabble_step(sh_q);
        cnt_q <= cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bcd  = sh_q[19:8];
  assign done = done_q;

endmodule

// File: rtl/tx_interface.sv
// Streams the ALU result as ASCII decimal plus terminator through the UART
// transmitter, then pulses rd. Define TX_SIGN_EN for a signed 5-byte frame.
module tx_interface
  import uart_pkg::*;
#(
  parameter logic [7:0] TERM = ASCII_LF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] result,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] din,
  output logic       rd
);

`ifdef TX_SIGN_EN
  localparam int unsigned NCHAR = 5;
`else
  localparam int unsigned NCHAR = 4;
`endif
  localparam logic [2:0] LAST_IDX = 3'(NCHAR - 1);

  tx_state_e   state_q;
  logic [2:0]  idx_q;
  logic        tx_start_q;
  logic        rd_q;
  logic [7:0]  din_q;

  logic        conv_start;
  logic        conv_done;
  logic [7:0]  conv_in;
  logic [11:0] bcd;
  logic [2:0]  sel_idx;
  logic [7:0]  sel_char;

  // The converter's shift register holds the latched value for the frame.
  assign conv_start = (state_q == ST_IDLE) && rx_empty;

`ifdef TX_SIGN_EN
  logic neg_q;
  assign conv_in = result[7] ? (8'd0 - result) : result;
`else
  assign conv_in = result;
`endif

  bin2bcd u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_in),
    .bcd   (bcd),
    .done  (conv_done)
  );

  assign sel_idx = (state_q == ST_CONV) ? 3'd0 : idx_q + 3'd1;

  always_comb begin
    sel_char = TERM;
`ifdef TX_SIGN_EN
    case (sel_idx)
      3'd0:    sel_char = neg_q ? ASCII_MINUS : ASCII_PLUS;
      3'd1:    sel_char = ASCII_0 + {4'd0, bcd[11:8]};
      3'd2:    sel_char = ASCII_0 + {4'd0, bcd[7:4]};
      3'd3:    sel_char = ASCII_0 + {4'd0, bcd[3:0]};
      default: sel_char = TERM;
    endcase
`else
    case (sel_idx)
      3'd0:    sel_char = ASCII_0 + {4'd0, bcd[11:8]};
      3'd1:    sel_char = ASCII_0 + {4'd0, bcd[7:4]};
      3'd2:    sel_char = ASCII_0 + {4'd0, bcd[3:0]};
      default: sel_char = TERM;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      rd_q       <= 1'b0;
      din_q      <= '0;
`ifdef TX_SIGN_EN
      neg_q      <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      rd_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_empty) begin
`ifdef TX_SIGN_EN
            neg_q <= result[7];
`endif
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          idx_q <= '0;
          if (conv_done) begin
            din_q      <= sel_char;
            tx_start_q <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (tx_done_tick) begin
            if (idx_q == LAST_IDX) begin
              rd_q    <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q      <= idx_q + 3'd1;
              din_q      <= sel_char;
              tx_start_q <= 1'b1;
              state_q    <= ST_LOAD;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign din      = din_q;
  assign rd       = rd_q;

endmodule

// File: tb/tb_tx_interface.sv
// Scoreboard bench for tx_interface: stimulus pushes expected frame bytes,
// a monitor pops and checks them on each tx_start; a transmitter model answers.
module tb_tx_interface;

  localparam logic [7:0] TERM_B = 8'd10;
`ifdef TX_SIGN_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b0;
  logic [7:0] result = 8'd0;
  logic       tick_model = 1'b0;
  logic       tick_spur = 1'b0;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       rd;

  assign tx_done_tick = tick_model | tick_spur;

  always #5 clk = ~clk;

  tx_interface #(.TERM(TERM_B)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_empty     (rx_empty),
    .result       (result),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .din          (din),
    .rd           (rd)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  int exp_start_cyc = 0;
  bit first_pending = 0;
  int last_tick_cyc = 0;
  int n_start = 0;
  int n_rd = 0;
  int rd_pending = 0;
  int exp_starts = 0;
  int exp_rds = 0;
  int tx_delay = 20;
  int tx_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // UART transmitter model: one tick tx_delay cycles after each tx_start
  always @(negedge clk) begin
    tick_model = 1'b0;
    if (reset) tx_cnt = 0;
    else begin
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tick_model = 1'b1;
          last_tick_cyc = cyc;
        end
      end
      if (tx_start) tx_cnt = tx_delay;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        n_start++;
        if (exp_q.size() == 0) chk("spurious_tx_start", int'(tx_start), 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("din_byte", int'(din), int'(mon_e));
          if (first_pending) begin
            chk("first_start_cycle", cyc, exp_start_cyc);
            first_pending = 0;
          end else chk("start_after_tick", cyc, last_tick_cyc + 1);
        end
      end
      if (rd) begin
        n_rd++;
        if (rd_pending == 0) chk("spurious_rd", int'(rd), 0);
        else begin
          rd_pending--;
          chk("rd_bytes_left", exp_q.size(), 0);
          chk("rd_after_tick", cyc, last_tick_cyc + 1);
        end
      end
    end
  end

  // Reference model: decimal digits by plain arithmetic
  function automatic void push_frame(input logic [7:0] v);
    int s;
    int m;
`ifdef TX_SIGN_EN
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    exp_q.push_back((s < 0) ? 8'd45 : 8'd43);
`else
    s = int'(v);
    m = s;
`endif
    exp_q.push_back(8'(48 + m / 100));
    exp_q.push_back(8'(48 + (m / 10) % 10));
    exp_q.push_back(8'(48 + m % 10));
    exp_q.push_back(TERM_B);
    rd_pending++;
    first_pending = 1;
    exp_starts += FL;
    exp_rds++;
  endfunction

  task automatic start_frame(input logic [7:0] v, input bit spur_conv);
    @(negedge clk);
    result = v;
    rx_empty = 1'b1;
    push_frame(v);
    exp_start_cyc = cyc + 9;
    if (spur_conv) begin
      repeat (2) @(negedge clk);
      tick_spur = 1'b1;
      repeat (3) @(negedge clk);
      tick_spur = 1'b0;
    end
  endtask

  task automatic finish_frame();
    bit seen;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (rd) begin
        rx_empty = 1'b0;
        seen = 1;
      end
    end
    if (!seen) begin
      chk("frame_rd_timeout", int'(rd), 1);
      rx_empty = 1'b0;
    end
  endtask

  task automatic quiet(input int n);
    repeat (n) @(negedge clk);
    chk("tx_start_total", n_start, exp_starts);
    chk("rd_total", n_rd, exp_rds);
  endtask

  task automatic wait_starts(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (n_start >= target) ok = 1;
    end
    if (!ok) chk("wait_tx_start_timeout", n_start, target);
  endtask

  task automatic run(input logic [7:0] v, input bit spur);
    start_frame(v, spur);
    finish_frame();
    quiet(30);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx_start", int'(tx_start), 0);
    chk("reset_din", int'(din), 0);
    chk("reset_rd", int'(rd), 0);
    reset = 1'b0;

    // spurious ticks while idle
    repeat (2) @(negedge clk);
    tick_spur = 1'b1;
    repeat (3) @(negedge clk);
    tick_spur = 1'b0;
    quiet(5);

    run(8'd7, 1'b1);
    run(8'd255, 1'b0);
    run(8'd0, 1'b1);

    // inputs change after the latch
    start_frame(8'd123, 1'b0);
    wait_starts(n_start + 1);
    result = 8'd99;
    rx_empty = 1'b0;
    finish_frame();
    quiet(30);

    // reset while waiting on the second byte
    start_frame(8'd123, 1'b0);
    wait_starts(exp_starts - FL + 2);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rx_empty = 1'b0;
    exp_q.delete();
    rd_pending = 0;
    first_pending = 0;
    exp_starts = exp_starts - FL + 2;
    exp_rds--;
    #1;
    chk("midreset_tx_start", int'(tx_start), 0);
    chk("midreset_din", int'(din), 0);
    chk("midreset_rd", int'(rd), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run(8'd42, 1'b0);

`ifdef TX_SIGN_EN
    run(8'hFB, 1'b0);
    run(8'h80, 1'b1);
    run(8'd17, 1'b0);
`endif

    for (int k = 0; k < 12; k++) begin
      tx_delay = int'($urandom_range(1, 30));
      run(8'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
